// File: rtl/onehot_digit_counter_pkg.sv
// Shared widths, reset values and helpers for the one-hot digit counter.
// The display stage consumes the one-hot byte, so its width is fixed here.
package onehot_digit_counter_pkg;

    localparam int DIGIT_W  = 3;
    localparam int ONEHOT_W = 8;

    localparam logic [DIGIT_W-1:0]  DIGIT_RST  = 3'd0;
    localparam logic [ONEHOT_W-1:0] ONEHOT_RST = 8'b0000_0001;

    localparam int NUM_BTN = 2;
    localparam int BTN_UP  = 0;
    localparam int BTN_DN  = 1;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2
    } step_dir_e;

    function automatic logic [ONEHOT_W-1:0] to_onehot(input logic [DIGIT_W-1:0] value);
        to_onehot = ONEHOT_W'(1) << value;
    endfunction

    // Opposing requests in the same cycle cancel each other out.
    function automatic step_dir_e arbitrate(input logic inc_req, input logic dec_req);
        step_dir_e dir;
        dir = STEP_NONE;
        if (inc_req && !dec_req) begin
            dir = STEP_INC;
        end else if (dec_req && !inc_req) begin
            dir = STEP_DEC;
        end
        arbitrate = dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-level debounce and a
// registered one-cycle pulse on each debounced press (never on release).
module btn_debounce #(
    parameter int DB_COUNT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);

    logic [1:0]       sync_reg;
    logic             level;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             deb_reg;
    logic             deb_next;
    logic             deb_d_reg;
    logic             press_reg;

    assign level = sync_reg[1];

    // Any cycle agreeing with the accepted level restarts qualification.
    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (level == deb_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == DB_LAST) begin
            deb_next = ~deb_reg;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            cnt_reg   <= '0;
            deb_reg   <= 1'b0;
            deb_d_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            cnt_reg   <= cnt_next;
            deb_reg   <= deb_next;
            deb_d_reg <= deb_reg;
            press_reg <= deb_reg & ~deb_d_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/onehot_digit_counter.sv
// Mod-8 digit counter driven by two debounced buttons and an optional
// auto-increment prescaler; outputs the digit in binary and one-hot form.
module onehot_digit_counter
    import onehot_digit_counter_pkg::*;
#(
    parameter int DB_COUNT = 50000,
    parameter int PRESCALE = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                btn_up,
    input  logic                btn_dn,
    input  logic                auto_en,
    output logic [ONEHOT_W-1:0] digit_onehot,
    output logic [DIGIT_W-1:0]  digit_bin,
    output logic                step_pulse
);

    localparam int PRE_W = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw[BTN_UP] = btn_up;
    assign btn_raw[BTN_DN] = btn_dn;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DB_COUNT(DB_COUNT)
            ) u_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .btn   (btn_raw[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    logic [PRE_W-1:0] pre_cnt_reg;
    logic [PRE_W-1:0] pre_cnt_next;
    logic             tick;

    // Prescaler holds while disabled but restarts from zero when auto mode is off.
    always_comb begin
        tick         = auto_en && ena && (pre_cnt_reg == PRE_LAST);
        pre_cnt_next = pre_cnt_reg;
        if (!auto_en) begin
            pre_cnt_next = '0;
        end else if (ena) begin
            pre_cnt_next = tick ? '0 : pre_cnt_reg + 1'b1;
        end
    end

    step_dir_e            step_dir;
    logic [DIGIT_W-1:0]   digit_bin_reg;
    logic [DIGIT_W-1:0]   digit_bin_next;
    logic [ONEHOT_W-1:0]  digit_onehot_reg;
    logic                 step_reg;
    logic                 step_next;

    assign step_dir = arbitrate(press[BTN_UP] | tick, press[BTN_DN]);

    // Requests arriving while disabled are dropped, not deferred.
    always_comb begin
        digit_bin_next = digit_bin_reg;
        step_next      = 1'b0;
        if (ena) begin
            case (step_dir)
                STEP_INC: begin
                    digit_bin_next = digit_bin_reg + 1'b1;
                    step_next      = 1'b1;
                end
                STEP_DEC: begin
                    digit_bin_next = digit_bin_reg - 1'b1;
                    step_next      = 1'b1;
                end
                default: begin
                    digit_bin_next = digit_bin_reg;
                    step_next      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg      <= '0;
            digit_bin_reg    <= DIGIT_RST;
            digit_onehot_reg <= ONEHOT_RST;
            step_reg         <= 1'b0;
        end else begin
            pre_cnt_reg      <= pre_cnt_next;
            digit_bin_reg    <= digit_bin_next;
            digit_onehot_reg <= to_onehot(digit_bin_next);
            step_reg         <= step_next;
        end
    end

    assign digit_bin    = digit_bin_reg;
    assign digit_onehot = digit_onehot_reg;
    assign step_pulse   = step_reg;

endmodule
